// File: rtl/dmem_line_responder.sv
// dmem_line_responder
//   Line-granular data memory that answers the data cache's refill and
//   writeback requests. Each request moves one 256-bit line. Completion is
//   signalled by a single-cycle mem_ack_o a fixed LATENCY cycles after the
//   request is accepted.
//
// Parameters:
//   LATENCY  cycles from acceptance edge to the edge that raises mem_ack_o
//            (legal 1..255)
//   LINE_AW  line-index width; the array holds 2**LINE_AW lines of 256 bits
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-low reset
//   mem_enable_i  request valid, held by the cache until it sees mem_ack_o
//   mem_write_i   1 = line write, 0 = line read (sampled at acceptance)
//   mem_addr_i    byte address; line index = mem_addr_i[LINE_AW+4:5]
//   mem_data_i    write line data (sampled at acceptance)
//   mem_data_o    read line data, valid in the ack cycle, held until the
//                 next read completes (writes leave it untouched)
//   mem_ack_o     single-cycle completion pulse
//   rd_count_o    completed reads, saturating   (only with DMEM_STATS_EN)
//   wr_count_o    completed writes, saturating  (only with DMEM_STATS_EN)
//   dbg_state_o   current FSM state (IDLE=0, BUSY=1, ACK=2)
//
// Handshake: a request is accepted on any edge where the FSM is IDLE and
// mem_enable_i is high; the address, write flag and write data are captured
// on that edge and later input changes are ignored. mem_ack_o is high for
// exactly one cycle; mem_enable_i is ignored while BUSY or ACK, so an enable
// still high in the first IDLE cycle after ACK is a fresh request.
//
// Optional build macro: DMEM_STATS_EN adds the read/write completion
// counters and their ports.
//
// The array is not reset and has no init port; simulation preloads it
// hierarchically through the 'mem' array.

module dmem_line_responder #(
  parameter int LATENCY = 10,
  parameter int LINE_AW = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic [255:0] mem_data_o,
  output logic         mem_ack_o,
`ifdef DMEM_STATS_EN
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o,
`endif
  output logic [1:0]   dbg_state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [255:0]       mem [2**LINE_AW];

  logic [1:0]         state;
  logic [7:0]         cnt;
  logic [LINE_AW-1:0] req_idx;
  logic               req_we;
  logic [255:0]       req_data;

  // The edge that completes the request: array write or read-data load,
  // ack raised, and stats bumped all happen here together.
  logic               commit;

  assign commit      = (state == BUSY) && (cnt == 8'd0);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      req_idx    <= '0;
      req_we     <= 1'b0;
      req_data   <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ack_o <= 1'b0;
          if (mem_enable_i) begin
            req_idx  <= mem_addr_i[LINE_AW+4:5];
            req_we   <= mem_write_i;
            req_data <= mem_data_i;
            cnt      <= LAT_M1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state     <= ACK;
            mem_ack_o <= 1'b1;
            if (!req_we) mem_data_o <= mem[req_idx];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          mem_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_ack_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Array write port. While rst_i is low the FSM is held in IDLE, so commit
  // cannot be true and a dropped write never reaches the array.
  always_ff @(posedge clk_i) begin
    if (commit && req_we) mem[req_idx] <= req_data;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_count_o <= 32'd0;
      wr_count_o <= 32'd0;
    end else if (commit) begin
      if (req_we) begin
        if (wr_count_o != 32'hFFFF_FFFF) wr_count_o <= wr_count_o + 32'd1;
      end else begin
        if (rd_count_o != 32'hFFFF_FFFF) rd_count_o <= rd_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: one instance at LATENCY=10 for
// latency, write/read, mid-request input changes, aliasing and reset; a
// second instance at LATENCY=1 for back-to-back requests.

module tb_dmem_line_responder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (LATENCY = 10) ----------------
  logic         en, we;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic [255:0] rdata;
  logic         ack;
  logic [1:0]   st;
`ifdef DMEM_STATS_EN
  logic [31:0]  rd_cnt, wr_cnt;
`endif

  dmem_line_responder #(.LATENCY(10), .LINE_AW(10)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .mem_enable_i (en),
    .mem_write_i  (we),
    .mem_addr_i   (addr),
    .mem_data_i   (wdata),
    .mem_data_o   (rdata),
    .mem_ack_o    (ack),
`ifdef DMEM_STATS_EN
    .rd_count_o   (rd_cnt),
    .wr_count_o   (wr_cnt),
`endif
    .dbg_state_o  (st)
  );

  // ---------------- DUT (LATENCY = 1) ----------------
  logic         en1, we1;
  logic [31:0]  addr1;
  logic [255:0] wdata1;
  logic [255:0] rdata1;
  logic         ack1;
  logic [1:0]   st1;
`ifdef DMEM_STATS_EN
  logic [31:0]  rd_cnt1, wr_cnt1;
`endif

  dmem_line_responder #(.LATENCY(1), .LINE_AW(10)) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .mem_enable_i (en1),
    .mem_write_i  (we1),
    .mem_addr_i   (addr1),
    .mem_data_i   (wdata1),
    .mem_data_o   (rdata1),
    .mem_ack_o    (ack1),
`ifdef DMEM_STATS_EN
    .rd_count_o   (rd_cnt1),
    .wr_count_o   (wr_cnt1),
`endif
    .dbg_state_o  (st1)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request on u_dut, waits (bounded) for ack, returns the number
  // of negedges from the acceptance edge to the ack cycle and the read data
  // seen in the ack cycle. With 'mutate' set, the request inputs are changed
  // right after acceptance to show they are ignored.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                         input logic mutate, output int lat, output logic [255:0] d_ack);
    @(negedge clk);
    en = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (mutate && lat == 1) begin
        addr  = 32'h0000_0040;
        we    = 1'b1;
        wdata = {8{32'hDEAD_BEEF}};
      end
      if (ack) break;
    end
    d_ack = rdata;
    en = 1'b0; we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] p_a5, p_w, p_1, p_2, p_5, p_j, d;
  int lat;
  int ack_seen;

  initial begin
    p_a5 = {32{8'hA5}};
    p_w  = {8{32'h1234_5678}};
    p_1  = {8{32'h1111_0001}};
    p_2  = {8{32'h2222_0002}};
    p_5  = {8{32'h5555_0005}};
    p_j  = {8{32'h0BAD_F00D}};

    rst_n = 1'b0;
    en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    en1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    u_dut.mem[3]  = p_a5;
    u_dut.mem[1]  = p_1;
    u_dut.mem[2]  = p_2;
    u_dut.mem[5]  = p_5;
    u_dut1.mem[1] = p_1;

    // Reset state
    #2;
    check_bit("rst_ack", ack, 1'b0);
    check("rst_data", rdata, '0);
    check("rst_state", 256'(st), 256'(2'd0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Read latency: accept at edge 0, ack only after edge 10
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = 32'h0000_0060;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("lat_ack_low", ack, 1'b0);
    end
    @(negedge clk);
    check_bit("lat_ack_high", ack, 1'b1);
    check("lat_data", rdata, p_a5);
    en = 1'b0;
    @(negedge clk);
    check_bit("lat_ack_after", ack, 1'b0);

    // Write then read the same line; write leaves mem_data_o alone
    run_req(1'b1, 32'h0000_0400, p_w, 1'b0, lat, d);
    check_int("wr_lat", lat, 11);
    check("wr_data_o_held", d, p_a5);
    check("wr_array", u_dut.mem[32], p_w);
    run_req(1'b0, 32'h0000_0400, '0, 1'b0, lat, d);
    check_int("rd_lat", lat, 11);
    check("raw_data", d, p_w);

    // Aliased address (upper bits and byte offset ignored) hits line 32
    run_req(1'b0, 32'h8000_8413, '0, 1'b0, lat, d);
    check("alias_data", d, p_w);

    // Input changes during BUSY are ignored
    run_req(1'b0, 32'h0000_0020, '0, 1'b1, lat, d);
    check_int("mid_lat", lat, 11);
    check("mid_data", d, p_1);
    check("mid_line1", u_dut.mem[1], p_1);
    check("mid_line2", u_dut.mem[2], p_2);

    // Reset during BUSY of a write to line 5
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 32'h0000_00A0; wdata = p_j;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("rstmid_busy", 256'(st), 256'(2'd1));
    rst_n = 1'b0;
    en = 1'b0; we = 1'b0;
    #1;
    check_bit("rstmid_ack", ack, 1'b0);
    check("rstmid_state", 256'(st), 256'(2'd0));
    check("rstmid_data", rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    check_int("rstmid_no_ack", ack_seen, 0);
    check("rstmid_line5", u_dut.mem[5], p_5);
    run_req(1'b0, 32'h0000_00A0, '0, 1'b0, lat, d);
    check_int("rstmid_new_lat", lat, 11);
    check("rstmid_new_data", d, p_5);

    // Back-to-back on LATENCY=1 with enable held through ACK and after
    @(negedge clk);
    en1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk); check_bit("b2b_c1", ack1, 1'b0);
    @(negedge clk); check_bit("b2b_c2", ack1, 1'b1);
    check("b2b_data1", rdata1, p_1);
    @(negedge clk); check_bit("b2b_c3", ack1, 1'b0);
    @(negedge clk); check_bit("b2b_c4", ack1, 1'b0);
    check("b2b_busy2", 256'(st1), 256'(2'd1));
    @(negedge clk); check_bit("b2b_c5", ack1, 1'b1);
    check("b2b_data2", rdata1, p_1);
    en1 = 1'b0;
    @(negedge clk); check_bit("b2b_c6", ack1, 1'b0);
    @(negedge clk); check_bit("b2b_c7", ack1, 1'b0);
    check("b2b_idle", 256'(st1), 256'(2'd0));

`ifdef DMEM_STATS_EN
    // Completion counters: cleared by reset, then 3 reads and 2 writes
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("stats_rd_rst", 256'(rd_cnt), '0);
    check("stats_wr_rst", 256'(wr_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 32'h0000_0060, '0, 1'b0, lat, d);
    run_req(1'b1, 32'h0000_0100, p_2, 1'b0, lat, d);
    run_req(1'b0, 32'h0000_0020, '0, 1'b0, lat, d);
    run_req(1'b1, 32'h0000_0120, p_1, 1'b0, lat, d);
    run_req(1'b0, 32'h0000_0100, '0, 1'b0, lat, d);
    check("stats_last_rd", d, p_2);
    @(negedge clk);
    check("stats_rd", 256'(rd_cnt), 256'(32'd3));
    check("stats_wr", 256'(wr_cnt), 256'(32'd2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
